// File: rtl/matrix_display_sequencer_pkg.sv
// Shared types and defaults for the matrix display sequencer.
package matx_disp_pkg;

    localparam int unsigned N       = 4;
    localparam int unsigned ELEM_W  = 32;
    localparam int unsigned SAT_MAX = 999;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        CAPTURE,
        SHOW
    } state_t;

    // Clamp a result element to the largest displayable value.
    function automatic logic [11:0] saturate12(input logic [ELEM_W-1:0] elem,
                                               input int unsigned sat_max = SAT_MAX);
        if (elem > ELEM_W'(sat_max)) begin
            return 12'(sat_max);
        end
        return elem[11:0];
    endfunction

endpackage

// File: rtl/matrix_display_sequencer_dwell_timer.sv
// Per-element dwell counter: counts while en, clears on clr, and flags the
// last tick of each DWELL_TICKS period on expire.
module dwell_timer #(
    parameter int unsigned DWELL_TICKS = 25_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int unsigned CW = (DWELL_TICKS > 2) ? $clog2(DWELL_TICKS) : 1;

    logic [CW-1:0] count;

    assign expire = en && (count == CW'(DWELL_TICKS - 1));

    // Dwell count: clear has priority, otherwise wrap at the end of the period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == CW'(DWELL_TICKS - 1)) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_display_sequencer.sv
// Launches the matrix core, snapshots its N*N results and scans them to the
// display path with start/pause/step control.
// Optional build macro MATX_DISP_WATCHDOG_EN adds a WAIT_DONE timeout that
// returns to IDLE and raises a sticky error.
module matrix_display_sequencer #(
    parameter int unsigned N              = matx_disp_pkg::N,
    parameter int unsigned ELEM_W         = matx_disp_pkg::ELEM_W,
    parameter int unsigned DWELL_TICKS    = 25_000_000,
    parameter int unsigned SAT_MAX        = matx_disp_pkg::SAT_MAX,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_req,
    input  logic                     pause,
    input  logic                     step,
    output logic                     core_start,
    input  logic                     core_done,
    input  logic [N*N*ELEM_W-1:0]    result_flat,
    output logic                     busy,
    output logic                     show_valid,
    output logic [$clog2(N)-1:0]     row_idx,
    output logic [$clog2(N)-1:0]     col_idx,
    output logic [11:0]              display_value,
    output logic                     saturated,
    output logic                     error
);

    import matx_disp_pkg::*;

    localparam int unsigned NE = N * N;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned KW = 2 * IW;

    state_t            state;
    state_t            state_next;
    logic              start_q;
    logic              step_q;
    logic              start_rise;
    logic              step_rise;
    logic [KW-1:0]     k;
    logic [KW-1:0]     k_disp;
    logic [ELEM_W-1:0] snap [NE];
    logic [ELEM_W-1:0] elem;
    logic              dwell_en;
    logic              dwell_clr;
    logic              dwell_expire;
    logic              timeout;

    // Registered copies of the level inputs for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            start_q <= start_req;
            step_q  <= step;
        end
    end

    assign start_rise = start_req & ~start_q;
    assign step_rise  = step & ~step_q;

`ifdef MATX_DISP_WATCHDOG_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_count;
    logic          error_q;

    assign timeout = (state == WAIT_DONE) && !core_done &&
                     (wd_count == TW'(TIMEOUT_CYCLES - 1));
    assign error   = error_q;

    // Watchdog: count cycles spent waiting for the core, sticky error on expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_count <= '0;
            error_q  <= 1'b0;
        end else begin
            if (state == WAIT_DONE && !core_done) begin
                wd_count <= wd_count + 1'b1;
            end else begin
                wd_count <= '0;
            end
            if (start_rise) begin
                error_q <= 1'b0;
            end else if (timeout) begin
                error_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start_req edges only matter in IDLE and SHOW.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start_rise) state_next = LAUNCH;
            LAUNCH:    state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (core_done) begin
                    state_next = CAPTURE;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            CAPTURE:   state_next = SHOW;
            SHOW:      if (start_rise) state_next = LAUNCH;
            default:   state_next = IDLE;
        endcase
    end

    // State-decoded control outputs.
    always_comb begin
        core_start = (state == LAUNCH);
        busy       = (state == LAUNCH) || (state == WAIT_DONE);
        show_valid = (state == SHOW);
    end

    assign dwell_en  = (state == SHOW) && !pause;
    assign dwell_clr = (state != SHOW) || step_rise;

    dwell_timer #(
        .DWELL_TICKS(DWELL_TICKS)
    ) u_dwell (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (dwell_en),
        .clr    (dwell_clr),
        .expire (dwell_expire)
    );

    // Snapshot capture and scan index; step and expiry together advance once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NE; i++) begin
                snap[i] <= '0;
            end
            k <= '0;
        end else if (state == CAPTURE) begin
            for (int unsigned i = 0; i < NE; i++) begin
                snap[i] <= result_flat[i*ELEM_W +: ELEM_W];
            end
            k <= '0;
        end else if (state == SHOW && (step_rise || dwell_expire)) begin
            k <= k + 1'b1;
        end
    end

    // During CAPTURE element 0 is taken straight from the core so the first
    // SHOW cycle already presents it.
    assign k_disp = (state == CAPTURE) ? '0 : k;
    assign elem   = (state == CAPTURE) ? result_flat[ELEM_W-1:0] : snap[k];

    // Registered display outputs, cleared when the watchdog abandons a launch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            display_value <= '0;
            saturated     <= 1'b0;
            row_idx       <= '0;
            col_idx       <= '0;
        end else if (timeout) begin
            display_value <= '0;
            saturated     <= 1'b0;
            row_idx       <= '0;
            col_idx       <= '0;
        end else if (state == CAPTURE || state == SHOW) begin
            display_value <= saturate12(elem, SAT_MAX);
            saturated     <= (elem > ELEM_W'(SAT_MAX));
            row_idx       <= k_disp[KW-1:IW];
            col_idx       <= k_disp[IW-1:0];
        end
    end

endmodule

// File: tb/tb_matrix_display_sequencer.sv
// Self-checking bench for matrix_display_sequencer (DWELL_TICKS = 4).
module tb_matrix_display_sequencer;

    localparam int unsigned N      = 4;
    localparam int unsigned ELEM_W = 32;
    localparam int unsigned DWELL  = 4;
    localparam int unsigned TMO    = 50;
    localparam int unsigned SATM   = 999;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  start_req;
    logic                  pause;
    logic                  step;
    logic                  core_done;
    logic [N*N*ELEM_W-1:0] result_flat;
    logic                  core_start;
    logic                  busy;
    logic                  show_valid;
    logic [1:0]            row_idx;
    logic [1:0]            col_idx;
    logic [11:0]           display_value;
    logic                  saturated;
    logic                  error;

    always #5 clk = ~clk;

    matrix_display_sequencer #(
        .N(N),
        .ELEM_W(ELEM_W),
        .DWELL_TICKS(DWELL),
        .SAT_MAX(SATM),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_req    (start_req),
        .pause        (pause),
        .step         (step),
        .core_start   (core_start),
        .core_done    (core_done),
        .result_flat  (result_flat),
        .busy         (busy),
        .show_valid   (show_valid),
        .row_idx      (row_idx),
        .col_idx      (col_idx),
        .display_value(display_value),
        .saturated    (saturated),
        .error        (error)
    );

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  k;
        logic [11:0] val;
        logic        sat;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] mdl [16];

    function automatic exp_t model_of(input int unsigned k);
        exp_t        e;
        logic [31:0] v;
        v     = mdl[k];
        e.k   = 4'(k);
        e.sat = (v > SATM);
        e.val = e.sat ? 12'(SATM) : v[11:0];
        return e;
    endfunction

    task automatic push_scan(input int unsigned first, input int unsigned cnt);
        for (int unsigned i = 0; i < cnt; i++) begin
            sbq.push_back(model_of((first + i) % 16));
        end
    endtask

    task automatic load_data();
        for (int unsigned i = 0; i < 16; i++) begin
            result_flat[i*ELEM_W +: ELEM_W] = mdl[i];
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string tag, input int unsigned limit);
        int unsigned n = 0;
        while (sbq.size() != 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val({tag, "_drain"}, sbq.size(), 0);
        sbq.delete();
    endtask

    // Scoreboard monitor: every newly displayed element is popped and compared.
    logic        prev_valid = 1'b0;
    logic [3:0]  prev_rc    = '0;
    int unsigned cyc        = 0;
    int unsigned last_cyc   = 0;
    int unsigned n_sess     = 0;
    logic        dwell_chk  = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (show_valid && (!prev_valid || {row_idx, col_idx} != prev_rc)) begin
            if (!prev_valid) n_sess = 0;
            n_sess++;
            if (dwell_chk && n_sess >= 3) check_val("dwell", cyc - last_cyc, DWELL);
            last_cyc = cyc;
            if (sbq.size() == 0) begin
                check_val("sb_extra", {28'b0, row_idx, col_idx}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sbq.pop_front();
                check_val("elem", {15'b0, row_idx, col_idx, display_value, saturated},
                          {15'b0, mon_e});
            end
        end
        prev_valid = show_valid;
        prev_rc    = {row_idx, col_idx};
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned wd_n;
        wd_n        = 0;
        reset_n     = 1'b1;
        start_req   = 1'b0;
        pause       = 1'b0;
        step        = 1'b0;
        core_done   = 1'b0;
        result_flat = '0;
        #2 reset_n  = 1'b0;
        #2;
        check_val("reset_outs", {11'b0, core_start, busy, show_valid, saturated, error,
                                 row_idx, col_idx, display_value}, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Run 1: elements 0..15, full scan with wrap back to element 0.
        for (int unsigned i = 0; i < 16; i++) mdl[i] = i;
        load_data();
        push_scan(0, 17);
        dwell_chk = 1'b1;
        start_req = 1'b1;
        tick();
        check_val("launch_pulse", {29'b0, core_start, busy, show_valid}, 3'b110);
        start_req = 1'b0;
        tick();
        check_val("launch_one_cycle", {30'b0, core_start, busy}, 2'b01);
        tick(8);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        check_val("show_entry", {26'b0, show_valid, busy, row_idx, col_idx}, 6'b100000);
        wait_drain("scan", 200);

        // Pause freezes the scan; step still advances exactly one element.
        dwell_chk = 1'b0;
        pause = 1'b1;
        tick(20);
        check_val("pause_hold", {28'b0, row_idx, col_idx}, 0);
        push_scan(1, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(3);
        check_val("step_in_pause", {28'b0, row_idx, col_idx}, 1);
        tick(10);
        check_val("step_once", {28'b0, row_idx, col_idx}, 1);

        // Step edge on the dwell-expiry cycle advances by one only.
        push_scan(2, 6);
        pause = 1'b0;
        tick(3);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(2);
        check_val("step_at_expire", {28'b0, row_idx, col_idx}, 2);

        // New core results during SHOW must not reach the display.
        for (int unsigned i = 0; i < 16; i++) mdl[i] = $urandom_range(0, 2000);
        mdl[1]  = 999;
        mdl[5]  = 1000;
        mdl[6]  = 32'hFFFF_FFFF;
        mdl[7]  = 4096 + 5;
        mdl[9]  = 0;
        mdl[10] = 998;
        mdl[11] = 1500;
        load_data();
        wait_drain("snapshot", 100);

        // Relaunch from SHOW, core_done held as a level for several cycles.
        start_req = 1'b1;
        @(posedge clk);
        #1;
        check_val("relaunch", {29'b0, show_valid, core_start, busy}, 3'b011);
        start_req = 1'b0;
        push_scan(0, 16);
        dwell_chk = 1'b1;
        tick();
        core_done = 1'b1;
        tick(3);
        core_done = 1'b0;
        wait_drain("run2", 200);

        // Asynchronous reset while waiting for the core.
        dwell_chk = 1'b0;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        tick(4);
        check_val("wait_busy", {30'b0, busy, show_valid}, 2'b10);
        reset_n = 1'b0;
        #1;
        check_val("reset_async", {11'b0, core_start, busy, show_valid, saturated, error,
                                  row_idx, col_idx, display_value}, 0);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check_val("idle_after_reset", {11'b0, core_start, busy, show_valid, saturated, error,
                                       row_idx, col_idx, display_value}, 0);
        core_done = 1'b1;
        tick(3);
        check_val("done_ignored_idle", {29'b0, busy, show_valid, core_start}, 0);
        core_done = 1'b0;

`ifdef MATX_DISP_WATCHDOG_EN
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        check_val("wd_launch", {31'b0, core_start}, 1);
        tick();
        while (busy && wd_n < 200) begin
            wd_n++;
            tick();
        end
        check_val("wd_cycles", wd_n, TMO);
        check_val("wd_error", {17'b0, error, busy, show_valid, display_value}, 15'h4000);
        tick(5);
        check_val("wd_sticky", {31'b0, error}, 1);
        start_req = 1'b1;
        tick();
        check_val("wd_clear", {30'b0, error, core_start}, 2'b01);
        start_req = 1'b0;
`else
        check_val("error_tied", {31'b0, error}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
